// File: rtl/multibyte_add_seq_if.sv
// Operand, adder-stage and result bundle for the byte-serial wide adder sequencer.
// The slave view belongs to the sequencer; the master view is the surrounding system.
interface multibyte_add_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;

  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/multibyte_add_seq.sv
// Byte-serial wide adder sequencer: drives an external 8-bit ripple adder stage
// LSB first and assembles a W-bit sum with unsigned carry and signed overflow.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multibyte_add_seq_if.slave bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_carry;
  logic [W-9:0]   r_acc;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [W-1:0]   r_out_sum;
  logic           r_out_cout;
  logic           r_out_ovf;
  logic           w_last;

  assign w_last = (r_idx == LAST_IDX);

  // Operands shift right one byte per RUN cycle, so the adder drive is always
  // the low byte of a register and falls to zero once the operation completes.
  assign bus.add_a     = r_a[7:0];
  assign bus.add_b     = r_b[7:0];
  assign bus.add_cin   = r_carry;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_ovf   = r_out_ovf;

  // Sequencer state, byte walk and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.in_a;
            r_b        <= bus.in_b;
            r_carry    <= bus.in_cin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a <= {8'h00, r_a[W-1:8]};
          r_b <= {8'h00, r_b[W-1:8]};
          if (w_last) begin
            // Top byte carries the sign bits used for signed overflow.
            r_out_sum   <= {bus.add_sum, r_acc};
            r_out_cout  <= bus.add_cout;
            r_out_ovf   <= (r_a[7] == r_b[7]) && (bus.add_sum[7] != r_a[7]);
            r_out_valid <= 1'b1;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_state     <= ST_DONE;
          end else begin
            r_acc[{r_idx, 3'b000} +: 8] <= bus.add_sum;
            r_carry <= bus.add_cout;
            r_idx   <= r_idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_idx       <= '0;
          r_a         <= '0;
          r_b         <= '0;
          r_carry     <= 1'b0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq: models the 8-bit adder stage and
// scores results through an expected-value queue.
module tb_multibyte_add_seq;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  multibyte_add_seq_if #(.NBYTES(NBYTES)) bus ();

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The combinational 8-bit ripple adder stage the sequencer drives
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'h00, bus.add_cin};

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] t;
    exp_t       e;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input exp_t e);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = c;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk);
    sb_q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_cin   = 1'($urandom_range(1));
  endtask

  task automatic wait_result(input bit chain, input bit rnd_rdy);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid) begin
        if (chain) begin
          n_vec++;
          if (bus.add_cin !== 1'b1 || bus.add_cout !== 1'b1) begin
            n_err++;
            $display("FAIL carry_chain add_cin=%b add_cout=%b required 1/1", bus.add_cin, bus.add_cout);
          end
        end
        bus.out_ready = rnd_rdy ? 1'($urandom_range(1)) : 1'b0;
      end
    end while (!bus.out_valid && lat < 40);
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || lat - 1 != NBYTES) begin
      n_err++;
      $display("FAIL latency out_valid=%b cycles=%0d required %0d", bus.out_valid, lat - 1, NBYTES);
    end
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty out_sum=%h required a queued entry", bus.out_sum);
    end else begin
      e = sb_q.pop_front();
      if (bus.out_sum !== e.sum || bus.out_cout !== e.cout || bus.out_ovf !== e.ovf) begin
        n_err++;
        $display("FAIL result sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                 bus.out_sum, bus.out_cout, bus.out_ovf, e.sum, e.cout, e.ovf);
      end
    end
    n_vec++;
    if (bus.add_a !== 8'h00 || bus.add_b !== 8'h00 || bus.add_cin !== 1'b0) begin
      n_err++;
      $display("FAIL idle_drive add_a=%h add_b=%h add_cin=%b required 00/00/0", bus.add_a, bus.add_b, bus.add_cin);
    end
  endtask

  task automatic release_result(input int gap);
    logic [W-1:0] s;
    logic         c;
    logic         o;
    s = bus.out_sum;
    c = bus.out_cout;
    o = bus.out_ovf;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== s ||
          bus.out_cout !== c || bus.out_ovf !== o) begin
        n_err++;
        $display("FAIL stall valid=%b in_ready=%b sum=%h required 1/0/%h", bus.out_valid, bus.in_ready, bus.out_sum, s);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sum !== s || bus.out_cout !== c) begin
      n_err++;
      $display("FAIL leave_done valid=%b in_ready=%b sum=%h required 0/1/%h", bus.out_valid, bus.in_ready, bus.out_sum, s);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input exp_t e, input int gap, input bit chain, input bit rnd_rdy);
    accept_op(a, b, c, e);
    wait_result(chain, rnd_rdy);
    release_result(gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 ||
        bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0 || bus.add_a !== 8'h00 ||
        bus.add_b !== 8'h00 || bus.add_cin !== 1'b0) begin
      n_err++;
      $display("FAIL reset in_ready=%b out_valid=%b sum=%h add_a=%h required 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.add_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, '{sum: 32'h0000_0003, cout: 1'b0, ovf: 1'b0}, 0, 1'b0, 1'b0);
  endtask

  task automatic test_carry_chain();
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, '{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0}, 1, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1}, 0, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, '{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b1}, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(32'hDEAD_BEEF, 32'h0102_0304, 1'b0, '{sum: 32'hDFAF_C1F3, cout: 1'b0, ovf: 1'b0}, 10, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, '{sum: 32'h2345_6789, cout: 1'b0, ovf: 1'b0}, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    exp_t dropped;
    accept_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.add_a !== 8'hFF || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_run add_a=%h out_valid=%b required ff/0", bus.add_a, bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    dropped = sb_q.pop_back();
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 ||
        bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0 || bus.add_a !== 8'h00 ||
        bus.add_b !== 8'h00 || bus.add_cin !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid in_ready=%b out_valid=%b sum=%h add_a=%h add_cin=%b required 1/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.add_a, bus.add_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
    end
    n_vec++;
    if (saw_valid) begin
      n_err++;
      $display("FAIL reset_discard out_valid=1 required 0 (dropped sum %h)", dropped.sum);
    end
    run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, '{sum: 32'h1010_1011, cout: 1'b0, ovf: 1'b0}, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_idle in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h00FF_00FF;
    bus.in_b     = 32'h0001_0001;
    bus.in_cin   = 1'b0;
    @(posedge clk);
    sb_q.push_back('{sum: 32'h0100_0100, cout: 1'b0, ovf: 1'b0});
    #1;
    // Second request held valid through RUN and DONE; it must wait for IDLE.
    bus.in_a = 32'hFFFF_FFFF;
    bus.in_b = 32'h0000_0001;
    wait_result(1'b0, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_transition in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    sb_q.push_back('{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0});
    #1;
    bus.in_valid = 1'b0;
    wait_result(1'b0, 1'b0);
    release_result(0);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom_range(1));
      case ($urandom_range(3))
        0:       b = ~a;
        1:       a = {a[W-1], {(W-1){~a[W-1]}}};
        default: b = b;
      endcase
      run_op(a, b, c, model(a, b, c), int'($urandom_range(3)), 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover entries=%0d required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
